muldiv_sequencer: RTL

Iterative sequencer for the RV32M multiply/divide operations, sitting in the EX stage beside the single-cycle ALU. It accepts one M-extension operation from the ID/EX register, stalls the pipeline while it runs, and returns a result for the EX/MEM register. It uses one shared add/subtract datapath over XLEN iterations, one bit per cycle, with sign correction applied at the end.

---
 rtl/muldiv_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer for the EX stage
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state, state_nxt;

  // latched operation context
  logic [2:0]        op_q;
  logic              negate_q;
  logic [XLEN-1:0]   addend_q;   // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] prod_q;     // product, or {partial remainder, dividend/quotient}
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;

  // decode of the incoming request
  logic            in_div, in_signed_a, in_signed_b, sign_a, sign_b, negate_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  assign in_div      = funct3[2];
  assign in_signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) |
                       (funct3 == 3'b100) | (funct3 == 3'b110);
  assign in_signed_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign sign_a      = in_signed_a & op_a[XLEN-1];
  assign sign_b      = in_signed_b & op_b[XLEN-1];
  assign mag_a       = sign_a ? -op_a : op_a;
  assign mag_b       = sign_b ? -op_b : op_b;
  // the remainder takes the dividend's sign; everything else the product/quotient sign
  assign negate_in   = (funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);

  assign div_zero    = in_div & (op_b == '0);
  assign div_ovf     = in_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
  assign special     = div_zero | div_ovf;
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign special_val = div_zero ? (funct3[1] ? op_a : ALL_ONES)
                                : (funct3[1] ? '0 : op_a);

  // shared adder: shift-add for multiply, trial subtract for restoring divide
  logic            is_div_q, sub_neg;
  logic [XLEN:0]   shifted, lhs, rhs, sum;
  logic [2*XLEN-1:0] prod_step;

  assign is_div_q = op_q[2];
  assign shifted  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign lhs      = is_div_q ? shifted : {1'b0, prod_q[2*XLEN-1:XLEN]};
  assign rhs      = is_div_q ? ~{1'b0, addend_q}
                             : (prod_q[0] ? {1'b0, addend_q} : '0);
  assign sum      = lhs + rhs + {{XLEN{1'b0}}, is_div_q};
  assign sub_neg  = sum[XLEN];
  assign prod_step = is_div_q
                   ? {(sub_neg ? shifted[XLEN-1:0] : sum[XLEN-1:0]), prod_q[XLEN-2:0], ~sub_neg}
                   : {sum, prod_q[XLEN-1:1]};

  // sign correction: a signed high product needs the full-width negate
  logic [2*XLEN-1:0] prod_fix;
  logic              pick_lo;
  logic [XLEN-1:0]   pick, fix_val;

  assign prod_fix = (negate_q & ~is_div_q) ? -prod_q : prod_q;
  assign pick_lo  = (op_q == 3'b000) | (op_q == 3'b100) | (op_q == 3'b101);
  assign pick     = pick_lo ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign fix_val  = (negate_q & is_div_q) ? -pick : pick;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE: stall = start & ~reset;
      S_CALC: begin stall = 1'b1; busy = 1'b1; end
      S_FIX:  begin stall = 1'b1; busy = 1'b1; end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // operand capture, iteration and result write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      negate_q <= 1'b0;
      addend_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q     <= funct3;
          negate_q <= negate_in;
          addend_q <= in_div ? mag_b : mag_a;
          prod_q   <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
          cnt_q    <= CNT_LOAD;
          if (special) result_q <= special_val;
        end
        S_CALC: begin
          prod_q <= prod_step;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
        end
        S_FIX:  result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
